// File: rtl/calc_operand_entry.sv
// calc_operand_entry: edge-detected keypad presses build BCD operands A/B and an operator, then hand them to the ALU via req/ack
module calc_operand_entry #(
    parameter int NDIG = 4,
    localparam int W = 4 * NDIG,
    localparam int CW = $clog2(NDIG + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          key_level,
    input  logic [3:0]    key_code,
    input  logic          alu_ack,
    output logic [W-1:0]  operand_a,
    output logic [W-1:0]  operand_b,
    output logic [1:0]    op_code,
    output logic          alu_req,
    output logic [W-1:0]  disp_value,
    output logic [CW-1:0] digit_count,
    output logic          ovf,
    output logic [1:0]    state_dbg
);
    typedef enum logic [1:0] {ENTER_A = 2'b00, ENTER_B = 2'b01, REQ = 2'b10} state_t;
    localparam logic [CW-1:0] FULL = CW'(NDIG);

    state_t state, state_n;
    logic [W-1:0] a_n, b_n, shifted;
    logic [1:0] op_n;
    logic [CW-1:0] cnt_n;
    logic ovf_n, key_prev, press, is_dig, is_op, is_eq, is_clr;

    assign press = key_level & ~key_prev;
    assign is_dig = key_code <= 4'd9;
    assign is_op = key_code >= 4'hA && key_code <= 4'hD;
    assign is_eq = key_code == 4'hE;
    assign is_clr = key_code == 4'hF;
    assign disp_value = (state == ENTER_A) ? operand_a : operand_b;
    assign shifted = W'({disp_value, key_code});
    assign alu_req = state == REQ;
    assign state_dbg = state;

    // key_prev follows the key even through reset so a key held across reset never fires
    always_ff @(posedge clk) begin
        key_prev <= key_level;
        if (reset) begin
            state <= ENTER_A;
            operand_a <= '0;
            operand_b <= '0;
            op_code <= '0;
            digit_count <= '0;
            ovf <= 1'b0;
        end else begin
            state <= state_n;
            operand_a <= a_n;
            operand_b <= b_n;
            op_code <= op_n;
            digit_count <= cnt_n;
            ovf <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n = operand_a;
        b_n = operand_b;
        op_n = op_code;
        cnt_n = digit_count;
        ovf_n = ovf;
        if (press && is_clr) begin
            state_n = ENTER_A;
            a_n = '0;
            b_n = '0;
            op_n = '0;
            cnt_n = '0;
            ovf_n = 1'b0;
        end else if (state == REQ) begin
            if (alu_ack) begin
                state_n = ENTER_A;
                a_n = '0;
                b_n = '0;
                cnt_n = '0;
                ovf_n = 1'b0;
            end
        end else if (press && is_dig) begin
            if (digit_count == FULL) begin
                ovf_n = 1'b1;
            end else if (key_code != 4'd0 || digit_count != '0) begin
                cnt_n = digit_count + 1'b1;
                a_n = (state == ENTER_A) ? shifted : operand_a;
                b_n = (state == ENTER_B) ? shifted : operand_b;
            end
        end else if (press && is_op) begin
            if (state == ENTER_A) begin
                op_n = 2'(key_code - 4'hA);
                state_n = ENTER_B;
                cnt_n = '0;
                b_n = '0;
                ovf_n = 1'b0;
            end else if (digit_count == '0) begin
                op_n = 2'(key_code - 4'hA);
            end
        end else if (press && is_eq && state == ENTER_B) begin
            state_n = REQ;
        end
    end
endmodule

// File: tb/tb_calc_operand_entry.sv
// tb_calc_operand_entry: directed key sequences against NDIG=4 and NDIG=8 instances sharing one keypad
module tb_calc_operand_entry;
    logic clk = 1'b0, reset = 1'b1, key_level = 1'b0, alu_ack = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [15:0] a4, b4, d4;
    logic [31:0] a8, b8, d8;
    logic [1:0] op4, op8, st4, st8;
    logic [2:0] c4;
    logic [3:0] c8;
    logic req4, req8, ovf4, ovf8;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    calc_operand_entry #(.NDIG(4)) u4 (
        .clk(clk), .reset(reset), .key_level(key_level), .key_code(key_code), .alu_ack(alu_ack),
        .operand_a(a4), .operand_b(b4), .op_code(op4), .alu_req(req4), .disp_value(d4),
        .digit_count(c4), .ovf(ovf4), .state_dbg(st4)
    );

    calc_operand_entry #(.NDIG(8)) u8 (
        .clk(clk), .reset(reset), .key_level(key_level), .key_code(key_code), .alu_ack(alu_ack),
        .operand_a(a8), .operand_b(b8), .op_code(op8), .alu_req(req8), .disp_value(d8),
        .digit_count(c8), .ovf(ovf8), .state_dbg(st8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // hold the key for 'hold' cycles, release, then idle one cycle; returns at a negedge
    task automatic press(input logic [3:0] code, input int hold = 1);
        @(negedge clk);
        key_code = code;
        key_level = 1'b1;
        repeat (hold) @(negedge clk);
        key_level = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        key_level = 1'b1;
        key_code = 4'h5;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a", a4, 0);
        chk("rst_b", b4, 0);
        chk("rst_cnt", c4, 0);
        chk("rst_st", st4, 0);
        chk("rst_req", req4, 0);
        chk("rst_ovf", ovf4, 0);
        chk("rst_op", op4, 0);
        key_level = 1'b0;
        press(4'h5, 4);
        chk("held5_a", a4, 16'h0005);
        chk("held5_cnt", c4, 1);

        press(4'hF);
        chk("clr_a", a4, 0);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        chk("full_ovf0", ovf4, 0);
        press(4'h5);
        chk("ovf_a", a4, 16'h1234);
        chk("ovf_cnt", c4, 4);
        chk("ovf_flag", ovf4, 1);
        chk("ovf_disp", d4, 16'h1234);
        press(4'hA);
        chk("plus_st", st4, 2'b01);
        chk("plus_ovf", ovf4, 0);
        chk("plus_op", op4, 2'b00);
        chk("plus_cnt", c4, 0);
        chk("plus_disp", d4, 0);

        press(4'hF);
        press(4'h0); press(4'h0);
        chk("lz_cnt", c4, 0);
        press(4'h7);
        press(4'hE);
        chk("eq_in_a_st", st4, 2'b00);
        press(4'hC);
        press(4'h4); press(4'h2);
        chk("mul_a", a4, 16'h0007);
        chk("mul_op", op4, 2'b10);
        chk("mul_b", b4, 16'h0042);
        chk("mul_disp", d4, 16'h0042);
        chk("mul_cnt", c4, 2);
        @(negedge clk) alu_ack = 1'b1;
        @(negedge clk) alu_ack = 1'b0;
        chk("stray_ack_st", st4, 2'b01);
        @(negedge clk);
        key_code = 4'hE;
        key_level = 1'b1;
        chk("req_pre", req4, 0);
        @(negedge clk) key_level = 1'b0;
        chk("req_rise", req4, 1);
        chk("req_st", st4, 2'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("req_hold%0d", i), req4, 1);
        end
        alu_ack = 1'b1;
        @(negedge clk) alu_ack = 1'b0;
        chk("ack_req", req4, 0);
        chk("ack_st", st4, 2'b00);
        chk("ack_a", a4, 0);
        chk("ack_b", b4, 0);
        chk("ack_op_kept", op4, 2'b10);

        press(4'h9); press(4'hA); press(4'hB); press(4'h3);
        chk("chg_op", op4, 2'b01);
        chk("chg_b", b4, 16'h0003);
        chk("chg_a", a4, 16'h0009);
        press(4'hD);
        chk("late_op_ignored", op4, 2'b01);

        press(4'hE);
        press(4'h8); press(4'hA);
        chk("reqlock_b", b4, 16'h0003);
        chk("reqlock_op", op4, 2'b01);
        chk("reqlock_cnt", c4, 1);
        chk("reqlock_st", st4, 2'b10);
        @(negedge clk);
        key_code = 4'hF;
        key_level = 1'b1;
        alu_ack = 1'b1;
        @(negedge clk);
        key_level = 1'b0;
        alu_ack = 1'b0;
        chk("clrack_req", req4, 0);
        chk("clrack_st", st4, 2'b00);
        chk("clrack_a", a4, 0);
        chk("clrack_b", b4, 0);
        chk("clrack_op", op4, 2'b00);
        chk("clrack_cnt", c4, 0);
        chk("clrack_ovf", ovf4, 0);

        for (int i = 1; i <= 8; i++) press(4'(i));
        chk("n8_a", a8, 32'h12345678);
        chk("n8_cnt", c8, 8);
        chk("n8_ovf0", ovf8, 0);
        press(4'h9);
        chk("n8_ovf1", ovf8, 1);
        chk("n8_a_kept", a8, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
